// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit buffer and its launch sequencer.
package uart_pkg;

    localparam int UART_BYTE_W  = 8;
    localparam int BUSY_TIMEOUT = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular byte FIFO with registered count/full/empty and a sticky overflow flag.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = UART_BYTE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    input  logic              clr_ovf,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              ovf_q, ovf_d;
    logic              push_ok;
    logic              pop_ok;

    // A pop at the same edge frees the slot, so a push while full is still accepted.
    assign pop_ok  = pop & ~empty_q;
    assign push_ok = push & (~full_q | pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        if (push && !push_ok) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = count_q;
    assign overflow = ovf_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer plus launch sequencer feeding the UART transmitter DATA/EN, paced by its STATUS.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | waiting for a queued byte and an idle transmitter
//   LAUNCH    | tx_en high for this single cycle
//   WAIT_BUSY | waiting for STATUS to drop; gives up after BUSY_TIMEOUT cycles
//   WAIT_DONE | frame in progress; waiting for STATUS to return to idle
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [UART_BYTE_W-1:0] wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [ADDR_W:0]        count,
    output logic                   overflow,
    input  logic                   clr_ovf,
    output logic [UART_BYTE_W-1:0] tx_data,
    output logic                   tx_en,
    input  logic                   tx_status
);

    localparam logic [1:0] TMR_LOAD = 2'(BUSY_TIMEOUT - 1);

    tx_state_e              state_q, state_d;
    logic [1:0]             tmr_q, tmr_d;
    logic [UART_BYTE_W-1:0] tx_data_q, tx_data_d;
    logic                   tx_en_q;
    logic                   fifo_pop;
    logic [UART_BYTE_W-1:0] fifo_rdata;
    logic                   fifo_empty;

    sync_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (UART_BYTE_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .clr_ovf   (clr_ovf),
        .full      (full),
        .empty     (fifo_empty),
        .count     (count),
        .overflow  (overflow)
    );

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        tx_data_d = tx_data_q;
        fifo_pop  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && tx_status) begin
                    fifo_pop  = 1'b1;
                    tx_data_d = fifo_rdata;
                    state_d   = LAUNCH;
                end
            end
            LAUNCH: begin
                tmr_d   = TMR_LOAD;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // A transmitter that never goes busy missed EN; the byte is dropped.
                if (!tx_status) begin
                    state_d = WAIT_DONE;
                end else if (tmr_q == 2'd0) begin
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q - 2'd1;
                end
            end
            WAIT_DONE: begin
                if (tx_status) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // tx_en comes straight from a flop so the transmitter never sees decode glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            tmr_q     <= '0;
            tx_data_q <= '0;
            tx_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            tx_data_q <= tx_data_d;
            tx_en_q   <= (state_d == LAUNCH);
        end
    end

    assign empty   = fifo_empty;
    assign tx_data = tx_data_q;
    assign tx_en   = tx_en_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a simple transmitter model answering tx_en.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       clr_ovf;
    logic [7:0] tx_data;
    logic       tx_en;
    logic       tx_status;

    int n_chk  = 0;
    int n_fail = 0;

    uart_tx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf),
        .tx_data   (tx_data),
        .tx_en     (tx_en),
        .tx_status (tx_status)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Transmitter model: goes busy for busy_len cycles when it sees tx_en.
    logic       hold_busy = 1'b0;
    logic       ignore_en = 1'b0;
    int         busy_len  = 10;
    int         busy_cnt  = 0;
    logic [7:0] en_data[$];
    int         en_cyc[$];
    int         rise_cyc[$];
    int         hi_cycles = 0;
    logic       tx_en_prev = 1'b0;

    assign tx_status = !hold_busy && (busy_cnt == 0);

    always @(negedge clk) begin
        if (tx_en === 1'b1) begin
            hi_cycles++;
            if (!tx_en_prev) begin
                en_data.push_back(tx_data);
                en_cyc.push_back(cyc);
            end
        end
        tx_en_prev = (tx_en === 1'b1);
        if (rst) begin
            busy_cnt = 0;
        end else if (busy_cnt != 0) begin
            busy_cnt--;
            if (busy_cnt == 0) rise_cyc.push_back(cyc);
        end else if (tx_en === 1'b1 && !ignore_en) begin
            busy_cnt = busy_len;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic clear_log();
        en_data.delete();
        en_cyc.delete();
        rise_cyc.delete();
        hi_cycles = 0;
    endtask

    task automatic wait_pulses(input int n, input int budget);
        int k;
        k = 0;
        while (en_data.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        clr_ovf = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_empty", empty, 1);
        chk("rst_count", count, 0);
        chk("rst_full", full, 0);
        chk("rst_tx_en", tx_en, 0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_ovf", overflow, 0);

        // single byte: pop one edge after the push, one-cycle tx_en
        clear_log();
        busy_len = 100;
        push_byte(8'hA5);
        chk("single_count_after_push", count, 1);
        chk("single_en_early", tx_en, 0);
        @(negedge clk);
        chk("single_en", tx_en, 1);
        chk("single_data", tx_data, 8'hA5);
        chk("single_count_after_pop", count, 0);
        @(negedge clk);
        chk("single_en_width", tx_en, 0);
        repeat (150) @(negedge clk);
        chk("single_pulses", en_data.size(), 1);
        chk("single_hi_cycles", hi_cycles, 1);
        chk("single_data_held", tx_data, 8'hA5);

        // burst order and inter-frame spacing
        clear_log();
        busy_len = 20;
        for (int i = 1; i <= 5; i++) push_byte(8'(i));
        wait_pulses(5, 600);
        chk("burst_pulses", en_data.size(), 5);
        for (int k = 0; k < en_data.size(); k++) chk("burst_data", en_data[k], 32'(k + 1));
        // STATUS rises at a negedge; FSM sees it at the next edge and pops at the one after
        for (int k = 1; k < en_cyc.size() && k <= rise_cyc.size(); k++)
            chk("burst_gap", 32'(en_cyc[k] - rise_cyc[k-1]), 2);
        chk("burst_hi_cycles", hi_cycles, 5);
        repeat (40) @(negedge clk);

        // full / overflow
        clear_log();
        hold_busy = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            push_byte(8'h10 + 8'(i));
            if (i == 14) chk("fill_not_full_15", full, 0);
            if (i == 15) begin
                chk("fill_full_16", full, 1);
                chk("fill_count_16", count, 16);
                chk("fill_no_ovf_16", overflow, 0);
            end
        end
        chk("ovf_set", overflow, 1);
        chk("ovf_count_held", count, 16);
        wr_en   = 1'b1;
        wr_data = 8'hEE;
        clr_ovf = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
        clr_ovf = 1'b0;
        chk("ovf_set_wins", overflow, 1);
        busy_len  = 3;
        hold_busy = 1'b0;
        wait_pulses(16, 1000);
        repeat (100) @(negedge clk);
        chk("drain_pulses", en_data.size(), 16);
        for (int k = 0; k < en_data.size(); k++) chk("drain_data", en_data[k], 32'(8'h10 + k));
        chk("drain_empty", empty, 1);
        chk("ovf_sticky", overflow, 1);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        chk("ovf_cleared", overflow, 0);

        // push at the pop edge of the only entry
        clear_log();
        hold_busy = 1'b1;
        push_byte(8'h3B);
        chk("pp_count_before", count, 1);
        hold_busy = 1'b0;
        wr_en     = 1'b1;
        wr_data   = 8'h3C;
        @(negedge clk);
        wr_en = 1'b0;
        chk("pp_count", count, 1);
        chk("pp_en", tx_en, 1);
        chk("pp_data", tx_data, 8'h3B);
        wait_pulses(2, 200);
        chk("pp_pulses", en_data.size(), 2);
        if (en_data.size() >= 2) chk("pp_second", en_data[1], 8'h3C);
        repeat (20) @(negedge clk);

        // missed EN: two WAIT_BUSY cycles, then the next byte goes
        clear_log();
        ignore_en = 1'b1;
        hold_busy = 1'b1;
        push_byte(8'h55);
        push_byte(8'h66);
        hold_busy = 1'b0;
        wait_pulses(2, 100);
        chk("miss_pulses", en_data.size(), 2);
        if (en_data.size() >= 2) begin
            chk("miss_first", en_data[0], 8'h55);
            chk("miss_second", en_data[1], 8'h66);
            chk("miss_gap", 32'(en_cyc[1] - en_cyc[0]), 4);
        end
        repeat (10) @(negedge clk);
        chk("miss_empty", empty, 1);
        chk("miss_no_extra", en_data.size(), 2);
        ignore_en = 1'b0;

        // reset during WAIT_DONE discards the queue
        clear_log();
        busy_len = 200;
        push_byte(8'h71);
        push_byte(8'h72);
        push_byte(8'h73);
        repeat (20) @(negedge clk);
        chk("rstmid_count", count, 2);
        chk("rstmid_pulses", en_data.size(), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid_count0", count, 0);
        chk("rstmid_empty", empty, 1);
        chk("rstmid_en", tx_en, 0);
        chk("rstmid_data", tx_data, 8'h00);
        repeat (50) @(negedge clk);
        chk("rstmid_no_launch", en_data.size(), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
